// File: rtl/decode_stage_n_pkg.sv
// decode_stage_n_pkg: opcode map, decoded-control struct and saturating count helper for the decode stage
`ifndef AXIS_CPU_COUNT_SAT
`define AXIS_CPU_COUNT_SAT(v) ((&(v)) ? (v) : (v) + 1'b1)
`endif
package decode_stage_n_pkg;
  localparam logic [2:0] OP_ALU  = 3'b100;
  localparam logic [2:0] OP_JMP  = 3'b110;
  localparam logic [2:0] OP_JMPC = 3'b111;
  localparam int BSEL_BIT = 4;
  typedef struct packed {
    logic reads_a;
    logic reads_x;
    logic decode_en;
    logic is_jmp;
  } dec_t;
  function automatic dec_t decode(input logic [2:0] op, input logic bsel);
    dec_t d;
    d.is_jmp    = (op == OP_JMP) || (op == OP_JMPC);
    d.reads_a   = (op == OP_ALU) || d.is_jmp;
    d.reads_x   = ((op == OP_ALU) || (op == OP_JMPC)) && bsel;
    d.decode_en = (op == OP_ALU) || (op == OP_JMPC);
    return d;
  endfunction
endpackage

// File: rtl/decode_fifo.sv
// decode_fifo: circular buffer of {instr, count} with flush, per-cycle count ageing and occupancy
module decode_fifo #(
  parameter int INSTR_W = 8,
  parameter int DEPTH   = 2,
  parameter int COUNT_W = 6,
  parameter int OW      = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic               age,
  input  logic [INSTR_W-1:0] din_instr,
  input  logic [COUNT_W-1:0] din_count,
  output logic [INSTR_W-1:0] head_instr,
  output logic [COUNT_W-1:0] head_count,
  output logic [OW-1:0]      occupancy,
  output logic               empty,
  output logic               full
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [INSTR_W-1:0] mem_i [DEPTH];
  logic [COUNT_W-1:0] mem_c [DEPTH];
  logic [PW-1:0]      rd, wr;
  logic               do_push, do_pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign empty      = occupancy == '0;
  assign full       = occupancy == OW'(DEPTH);
  assign do_push    = push && !full;
  assign do_pop     = pop && !empty;
  assign head_instr = mem_i[rd];
  assign head_count = mem_c[rd];
  // Ageing touches every slot; stale slots are overwritten on push, and a popped head leaves anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd        <= '0;
      wr        <= '0;
      occupancy <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_i[i] <= '0;
        mem_c[i] <= '0;
      end
    end else if (flush) begin
      rd        <= '0;
      wr        <= '0;
      occupancy <= '0;
    end else begin
      rd        <= do_pop ? nxt(rd) : rd;
      wr        <= do_push ? nxt(wr) : wr;
      occupancy <= occupancy + OW'(do_push) - OW'(do_pop);
      for (int i = 0; i < DEPTH; i++) begin
        if (do_push && wr == PW'(i)) begin
          mem_i[i] <= din_instr;
          mem_c[i] <= din_count;
        end else if (age) begin
          mem_c[i] <= `AXIS_CPU_COUNT_SAT(mem_c[i]);
        end
      end
    end
  end
endmodule

// File: rtl/decode_stage_n.sv
// decode_stage_n: instruction decode, RAW-hazard stall and elastic buffering between fetch and execute
// Optional DECODE_STALL_STATS_EN adds a saturating 16-bit stall_cycles counter output.
module decode_stage_n
  import decode_stage_n_pkg::*;
#(
  parameter int INSTR_W = 8,
  parameter int DEPTH   = 2,
  parameter int COUNT_W = 6,
  parameter int NUM_HAZ = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [INSTR_W-1:0]           instr_in,
  input  logic                         flush,
  input  logic [NUM_HAZ-1:0]           writes_A,
  input  logic [NUM_HAZ-1:0]           writes_X,
  output logic                         B_sel,
  output logic [3:0]                   ALU_sel,
  output logic                         ALU_en,
  output logic [INSTR_W-1:0]           instr_out,
  input  logic                         PC_en,
  input  logic [COUNT_W-1:0]           icount,
  output logic [COUNT_W-1:0]           ocount,
  input  logic                         prev_vld,
  output logic                         rdy,
  output logic                         vld,
  input  logic                         next_rdy,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
`ifdef DECODE_STALL_STATS_EN
  ,
  output logic [15:0]                  stall_cycles
`endif
);
  dec_t               dec;
  logic               stalled, full, empty, accept;
  logic [COUNT_W-1:0] cnt_in;
  assign dec     = decode(instr_in[INSTR_W-1 -: 3], instr_in[BSEL_BIT]);
  assign stalled = (dec.reads_a && |writes_A) || (dec.reads_x && |writes_X);
  // rdy is built only from local state and hazards so no ready path runs through next_rdy.
  assign rdy     = !full && !stalled && !flush;
  assign accept  = prev_vld && rdy;
  assign vld     = !empty;
  assign ALU_en  = dec.decode_en && accept;
  assign B_sel   = instr_in[BSEL_BIT];
  assign ALU_sel = dec.is_jmp ? 4'd0 : instr_in[3:0];
  assign cnt_in  = PC_en ? `AXIS_CPU_COUNT_SAT(icount) : icount;
  decode_fifo #(
    .INSTR_W(INSTR_W),
    .DEPTH  (DEPTH),
    .COUNT_W(COUNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (accept),
    .pop       (vld && next_rdy),
    .flush     (flush),
    .age       (PC_en),
    .din_instr (instr_in),
    .din_count (cnt_in),
    .head_instr(instr_out),
    .head_count(ocount),
    .occupancy (occupancy),
    .empty     (empty),
    .full      (full)
  );
`ifdef DECODE_STALL_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cycles <= '0;
    else if (prev_vld && stalled && !flush && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
  end
`endif
endmodule

// File: tb/tb_decode_stage_n.sv
// tb_decode_stage_n: directed self-checking bench for decode_stage_n (DEPTH=2, 8-bit instructions)
module tb_decode_stage_n;
  logic       clk = 1'b0;
  logic       rst_n, flush, B_sel, ALU_en, PC_en, prev_vld, rdy, vld, next_rdy;
  logic [7:0] instr_in, instr_out;
  logic [1:0] writes_A, writes_X, occupancy;
  logic [3:0] ALU_sel;
  logic [5:0] icount, ocount;
`ifdef DECODE_STALL_STATS_EN
  logic [15:0] stall_cycles;
`endif
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  decode_stage_n #(.INSTR_W(8), .DEPTH(2), .COUNT_W(6), .NUM_HAZ(2)) dut (
    .clk(clk), .rst_n(rst_n), .instr_in(instr_in), .flush(flush),
    .writes_A(writes_A), .writes_X(writes_X), .B_sel(B_sel), .ALU_sel(ALU_sel),
    .ALU_en(ALU_en), .instr_out(instr_out), .PC_en(PC_en), .icount(icount),
    .ocount(ocount), .prev_vld(prev_vld), .rdy(rdy), .vld(vld),
    .next_rdy(next_rdy), .occupancy(occupancy)
`ifdef DECODE_STALL_STATS_EN
    , .stall_cycles(stall_cycles)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0; prev_vld = 1'b0; instr_in = 8'h80; flush = 1'b0;
    writes_A = '0; writes_X = '0; next_rdy = 1'b1; PC_en = 1'b0; icount = '0;
    #3;
    chk("rst_vld", vld, 0); chk("rst_rdy", rdy, 1); chk("rst_instr_out", instr_out, 0);
    chk("rst_ocount", ocount, 0); chk("rst_occ", occupancy, 0); chk("rst_alu_en", ALU_en, 0);
    tick(); rst_n = 1'b1; tick();
    // continuous stream of ALU-IMM instructions
    for (int i = 0; i < 4; i++) begin
      instr_in = 8'h80 + 8'(i); prev_vld = 1'b1; #1;
      chk("stream_alu_en", ALU_en, 1); chk("stream_rdy", rdy, 1);
      if (i == 0) chk("stream_vld0", vld, 0);
      else begin
        chk("stream_head", instr_out, 32'h80 + i - 1); chk("stream_vld", vld, 1); chk("stream_occ", occupancy, 1);
      end
      tick();
    end
    prev_vld = 1'b0; #1;
    chk("stream_last_head", instr_out, 8'h83); chk("stream_last_vld", vld, 1); chk("stream_idle_en", ALU_en, 0);
    tick(); #1;
    chk("stream_drain_vld", vld, 0); chk("stream_drain_occ", occupancy, 0);
    // X hazard holds the ALU-X instruction for three cycles
    instr_in = 8'h98; writes_X = 2'b10; prev_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1; chk("hazx_rdy", rdy, 0); chk("hazx_alu_en", ALU_en, 0);
      chk("hazx_bsel", B_sel, 1); chk("hazx_alusel", ALU_sel, 8);
      tick();
    end
    writes_X = 2'b00; #1;
    chk("hazx_release_rdy", rdy, 1); chk("hazx_release_en", ALU_en, 1);
    tick(); prev_vld = 1'b0; #1;
    chk("hazx_head", instr_out, 8'h98); chk("hazx_vld", vld, 1);
    tick();
    // decode/hazard corner cases with no valid upstream
    instr_in = 8'h81; writes_A = 2'b01; #1; chk("haza_alu_rdy", rdy, 0);
    writes_A = 2'b00; writes_X = 2'b11; #1; chk("alu_imm_ignores_x", rdy, 1);
    instr_in = 8'hC5; #1; chk("jmp_ignores_x", rdy, 1); chk("jmp_alusel", ALU_sel, 0);
    writes_A = 2'b10; #1; chk("jmp_reads_a", rdy, 0);
    instr_in = 8'hF3; writes_A = 2'b00; #1;
    chk("jmpc_reads_x", rdy, 0); chk("jmpc_alusel", ALU_sel, 0); chk("jmpc_bsel", B_sel, 1);
    writes_X = 2'b00; prev_vld = 1'b1; #1; chk("jmpc_alu_en", ALU_en, 1);
    tick(); prev_vld = 1'b0; #1; chk("jmpc_head", instr_out, 8'hF3);
    tick(); #1; chk("jmpc_drain", vld, 0);
    instr_in = 8'hC5; prev_vld = 1'b1; #1; chk("jmp_no_alu_en", ALU_en, 0);
    prev_vld = 1'b0;
    // back-pressure fills DEPTH=2 and blocks the third push
    next_rdy = 1'b0; prev_vld = 1'b1; instr_in = 8'h81; #1; chk("bp_rdy0", rdy, 1);
    tick(); instr_in = 8'h82; #1; chk("bp_rdy1", rdy, 1); chk("bp_occ1", occupancy, 1);
    tick(); instr_in = 8'h83; #1;
    chk("bp_full_rdy", rdy, 0); chk("bp_occ2", occupancy, 2); chk("bp_full_en", ALU_en, 0); chk("bp_vld", vld, 1);
    tick(); #1; chk("bp_hold_rdy", rdy, 0); chk("bp_hold_occ", occupancy, 2);
    next_rdy = 1'b1; #1; chk("bp_no_comb_path", rdy, 0); chk("bp_head0", instr_out, 8'h81);
    tick(); #1;
    chk("bp_accept3_rdy", rdy, 1); chk("bp_accept3_en", ALU_en, 1);
    chk("bp_occ_after_pop", occupancy, 1); chk("bp_head1", instr_out, 8'h82);
    tick(); prev_vld = 1'b0; #1; chk("bp_pushpop_occ", occupancy, 1); chk("bp_head2", instr_out, 8'h83);
    tick(); #1; chk("bp_drain_occ", occupancy, 0);
    // count saturation at head
    next_rdy = 1'b0; PC_en = 1'b1; icount = 6'd62; instr_in = 8'h84; prev_vld = 1'b1; #1;
    chk("sat_accept", ALU_en, 1);
    tick(); prev_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1; chk("sat_ocount", ocount, 63); tick();
    end
    // flush with two entries and upstream valid
    PC_en = 1'b0; icount = '0; instr_in = 8'h85; prev_vld = 1'b1; #1; chk("fl_pre_rdy", rdy, 1);
    tick(); #1; chk("fl_occ2", occupancy, 2);
    flush = 1'b1; #1;
    chk("fl_rdy", rdy, 0); chk("fl_alu_en", ALU_en, 0); chk("fl_vld_pre", vld, 1); chk("fl_occ_pre", occupancy, 2);
    tick(); flush = 1'b0; prev_vld = 1'b0; #1;
    chk("fl_vld_post", vld, 0); chk("fl_occ_post", occupancy, 0);
    // buffered count ages only while PC_en is high
    icount = 6'd5; instr_in = 8'h86; prev_vld = 1'b1; #1;
    tick(); prev_vld = 1'b0; PC_en = 1'b1; #1; chk("age_start", ocount, 5);
    tick(); #1; chk("age_inc", ocount, 6);
    PC_en = 1'b0; tick(); #1; chk("age_hold", ocount, 6);
    // asynchronous reset discards entries immediately
    rst_n = 1'b0; #1;
    chk("arst_vld", vld, 0); chk("arst_occ", occupancy, 0); chk("arst_instr", instr_out, 0); chk("arst_ocount", ocount, 0);
    tick(); rst_n = 1'b1; next_rdy = 1'b1;
`ifdef DECODE_STALL_STATS_EN
    instr_in = 8'h81; writes_A = 2'b01; prev_vld = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    writes_A = 2'b00; prev_vld = 1'b0; #1; chk("stats_count", stall_cycles, 5);
    rst_n = 1'b0; #1; chk("stats_reset", stall_cycles, 0);
    tick(); rst_n = 1'b1;
`endif
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/decode_stage_n.md
# decode_stage_n

Parametrised decode stage for the AXI-Stream CPU controller. It sits between fetch (stage 0) and execute (stage 2). It decodes the incoming instruction into the ALU control outputs and checks RAW hazards against a configurable number of downstream writer stages. Accepted instructions are held in a DEPTH-entry elastic buffer, each carrying a saturating cycle count. A branch mispredict flushes the buffer.

## Interface
Parameters:
- `INSTR_W`, default 8: instruction width; opcode is `[INSTR_W-1:INSTR_W-3]`, B-select is bit 4, ALU op is `[3:0]`.
- `DEPTH`, default 2: buffer entries, 1..8.
- `COUNT_W`, default 6: cycle-count width.
- `NUM_HAZ`, default 2: number of downstream stages checked for hazards.

Ports:
- `clk`  in  1: the single clock.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `instr_in`  in  INSTR_W: instruction from fetch.
- `flush`  in  1: branch mispredict; synchronously empties the buffer.
- `writes_A`  in  NUM_HAZ: bit i set means downstream stage i will write A.
- `writes_X`  in  NUM_HAZ: bit i set means downstream stage i will write X.
- `B_sel`  out  1: ALU B operand select (1 = X, 0 = IMM), combinational on `instr_in`.
- `ALU_sel`  out  4: ALU op; 0 for jumps, else `instr_in[3:0]`.
- `ALU_en`  out  1: hot signal; ALU instruction or conditional jump, gated by accept.
- `instr_out`  out  INSTR_W: head-of-buffer instruction.
- `PC_en`  in  1: count-increment enable.
- `icount`  in  COUNT_W: incoming instruction's count.
- `ocount`  out  COUNT_W: head entry's count.
- `prev_vld`  in  1: upstream valid.
- `rdy`  out  1: upstream ready.
- `vld`  out  1: downstream valid.
- `next_rdy`  in  1: downstream ready.
- `occupancy`  out  $clog2(DEPTH+1): current number of buffered entries.

## Operation
- **Decode:** uses the opcodes from `axis_cpu_defs.vh`.
  - Reads A: ALU or JMP.
  - Reads X: ALU with bit4=1, or conditional JMP with bit4=1.
- **Stall:** `stalled = (readsA && |writes_A) || (readsX && |writes_X)`.
- **Ready:** `rdy = !full && !stalled && !flush`. `rdy` never depends on `next_rdy`, so there is no combinational ready path.
- **Accept** = `prev_vld && rdy`. Push `{instr_in, cnt_in}`, where `cnt_in = icount + PC_en`, saturating at 2^COUNT_W−1.
- **Hot signal:** `ALU_en = decode_en && accept`. `B_sel` and `ALU_sel` are not gated.
- **Pop** = `vld && next_rdy`. `vld = !empty`. `instr_out` and `ocount` present the head entry.
- **Count ageing:** every cycle with `PC_en=1`, every buffered entry's count increments, saturating. An entry popped in that same cycle is not incremented.
- **Simultaneous push and pop:** legal whenever not full; occupancy is unchanged. When full, push is blocked even if a pop occurs.
- **Flush:** in the flush cycle the push is suppressed (`rdy=0`, `ALU_en=0`). The buffer is emptied at the next edge. `vld` is still driven from pre-flush state during the flush cycle, and any pop in that cycle is irrelevant.
- **Reset:** all outputs deassert; buffer empty; counts 0; stats counter 0.

## Timing
- Reset values: `vld=0`; `rdy=1` if not stalled; `instr_out=0`; `ocount=0`; `occupancy=0`; `ALU_en=0`.
- Latency: 1 cycle from accept to `vld` when the buffer is empty.
- Throughput: 1 instruction/cycle for DEPTH≥2. DEPTH=1 gives 1 per 2 cycles under continuous flow.
- Hazard signals are sampled combinationally in the accept cycle.
- Deasserting `rst_n` mid-transfer discards all entries immediately (asynchronous).
- Pointers wrap modulo DEPTH. Full: occupancy==DEPTH. Empty: occupancy==0.

## Configuration
- `DECODE_STALL_STATS_EN`
  - Defined: adds output `stall_cycles` (16 bits). It increments, saturating at 0xFFFF, each cycle with `prev_vld && stalled && !flush`, and clears on reset.
  - Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Opcode constants and field positions stay in shared `axis_cpu_defs.vh`. Add `AXIS_CPU_COUNT_SAT` there (the saturating-increment helper macro).
- One sub-module, `decode_fifo`: DEPTH×(INSTR_W+COUNT_W) circular buffer with push, pop, flush, count ageing and occupancy.
- Decode, stall and handshake gating live in `decode_stage_n`.

## Test plan
- Reset, then stream 4 ALU-IMM instrs (0x80..0x83) with `next_rdy=1`, `PC_en=0`, `icount=0` → each appears 1 cycle after accept; `vld` is continuous; `ALU_en` pulses once per instruction.
- ALU-X instr 0x98 with `writes_X=2'b10` for 3 cycles → `rdy=0` and `ALU_en=0` for 3 cycles; accepted on cycle 4.
- `next_rdy=0`, DEPTH=2, push 3 instrs → `rdy=0` after 2; `occupancy=2`; 3rd accepted 1 cycle after `next_rdy` rises.
- `icount=62`, `PC_en=1` held, hold at head 3 cycles → `ocount` goes 63, 63, 63 (saturates).
- `flush` with `occupancy=2` and `prev_vld=1` → no push that cycle; next cycle `vld=0`, `occupancy=0`.
- With `DECODE_STALL_STATS_EN` defined, 5 stalled cycles → `stall_cycles=5`; it reads 0 after `rst_n` pulse.
